// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - op codes accepted on the op port (codes 6 and 7 are no-ops)
//   - FSM state encoding
//   - iteration count of the bit-serial datapath
package muldiv_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MD_MULTU = 3'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the bit-serial multiply/divide datapath (combinational).
// Ports:
//   acc      in   2*WIDTH  accumulator {upper, lower}
//   opnd     in   WIDTH    multiplicand magnitude (mul) or divisor magnitude (div)
//   in_bit   in   1        current multiplier LSB (mul) or next dividend MSB (div)
//   is_div   in   1        0: shift-add multiply step, 1: restoring divide step
//   acc_next out  2*WIDTH  accumulator after this step
// Multiply: upper half += opnd when in_bit is set, then the whole accumulator
// shifts right one place with the carry entering at the top.
// Divide: {remainder, quotient}; the remainder shifts in the dividend bit,
// the divisor is trial-subtracted and the quotient bit enters at the bottom.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               in_bit,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, opnd} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], in_bit};
    // The running remainder stays below the divisor, so when rem_sh >= opnd
    // the difference fits in WIDTH bits and bit WIDTH is a clean borrow flag.
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request strobe, honoured only when idle
//   op     in   3      MD_MULTU/MD_MULT/MD_DIVU/MD_DIV/MD_MTHI/MD_MTLO
//   X      in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   Y      in   WIDTH  multiplier / divisor
//   busy   out  1      iterative operation in flight
//   done   out  1      one-cycle pulse after HI/LO take a mul/div result
//   hi     out  WIDTH  product upper half or remainder
//   lo     out  WIDTH  product lower half or quotient
// Mul/div run on magnitudes for WIDTH iterations, then one fix-up cycle
// applies the sign correction and writes HI/LO (33 cycles from start).
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER_COUNT);

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
  logic [WIDTH-1:0]   opnd, shreg, mag_x, mag_y, quo_fix, rem_fix;
  logic               is_div, neg_x, neg_y, y_zero;
  logic               op_signed, op_div, accept_md;

  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIVU) || (op == MD_DIV);
    accept_md = start && (state == IDLE) &&
                ((op == MD_MULTU) || (op == MD_MULT) || op_div);
    // Negating the most negative value wraps back to itself, which is the
    // correct magnitude when read as unsigned.
    mag_x = (op_signed && X[WIDTH-1]) ? -X : X;
    mag_y = (op_signed && Y[WIDTH-1]) ? -Y : Y;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .in_bit   (is_div ? shreg[WIDTH-1] : shreg[0]),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  always_comb begin
    prod_fix = (neg_x ^ neg_y) ? -acc : acc;
    quo_fix  = (neg_x ^ neg_y) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_x ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_md) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(ITER_COUNT - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      shreg  <= '0;
      is_div <= 1'b0;
      neg_x  <= 1'b0;
      neg_y  <= 1'b0;
      y_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_md) begin
            is_div <= op_div;
            neg_x  <= op_signed & X[WIDTH-1];
            neg_y  <= op_signed & Y[WIDTH-1];
            y_zero <= (Y == '0);
            // Divide iterates over the dividend; multiply over the multiplier.
            opnd   <= op_div ? mag_y : mag_x;
            shreg  <= op_div ? mag_x : mag_y;
            acc    <= '0;
            cnt    <= '0;
          end else if (start && op == MD_MTHI) begin
            hi <= X;
          end else if (start && op == MD_MTLO) begin
            lo <= X;
          end
        end
        RUN: begin
          acc   <= acc_next;
          cnt   <= cnt + CNT_W'(1);
          shreg <= is_div ? (shreg << 1) : (shreg >> 1);
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (y_zero) begin
            // Remainder is the dividend magnitude here; restoring its sign
            // hands back X exactly.
            hi <= rem_fix;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .X     (x),
    .Y     (y),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start for one edge; returns at the negedge after the sampling edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    x = a;
    y = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input string name, input logic [31:0] hold_hi,
                           input logic [31:0] hold_lo, output int cycles);
    cycles = 0;
    while (!done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (cycles == 20) begin
        check({name, " hold hi"}, hi, hold_hi);
        check({name, " hold lo"}, lo, hold_lo);
      end
    end
  endtask

  initial begin
    int cyc;
    int dcount;
    logic [31:0] prev_hi, prev_lo;

    vecs[0] = '{"multu max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult -3*7",   MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"div -7/2",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu 100/7",  MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{"divu by 0",   MD_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    vecs[5] = '{"div min/-1",  MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"div -7/0",    MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7] = '{"mult min*min",MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{"div 7/-2",    MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst = 1'b0;

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; x = 32'hA5A5A5A5;
    @(negedge clk);
    check("mthi hi", hi, 32'hA5A5A5A5);
    check("mthi lo", lo, 32'd0);
    check("mthi busy", {31'd0, busy}, 32'd0);
    op = MD_MTLO; x = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h5A5A5A5A);
    check("mtlo hi", hi, 32'hA5A5A5A5);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    check("mtlo done", {31'd0, done}, 32'd0);

    // Table-driven mul/div vectors
    prev_hi = 32'hA5A5A5A5;
    prev_lo = 32'h5A5A5A5A;
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].x, vecs[i].y);
      check({vecs[i].name, " busy"}, {31'd0, busy}, 32'd1);
      check({vecs[i].name, " early hi"}, hi, prev_hi);
      wait_done(vecs[i].name, prev_hi, prev_lo, cyc);
      check({vecs[i].name, " latency"}, cyc, 32'd33);
      check({vecs[i].name, " hi"}, hi, vecs[i].hi);
      check({vecs[i].name, " lo"}, lo, vecs[i].lo);
      @(negedge clk);
      check({vecs[i].name, " done pulse"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, " idle"}, {31'd0, busy}, 32'd0);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // MULTU 3*5 with a DIVU start while busy: must be ignored
    start_op(MD_MULTU, 32'd3, 32'd5);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        start = 1'b1; op = MD_DIVU; x = 32'd99; y = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ignored start latency", cyc, 32'd33);
    check("ignored start hi", hi, 32'd0);
    check("ignored start lo", lo, 32'd15);
    @(negedge clk);
    check("ignored start no queue", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-operation
    start_op(MD_MULTU, 32'd2, 32'd2);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst done", {31'd0, done}, 32'd0);
    check("async rst hi", hi, 32'd0);
    check("async rst lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no done after rst", dcount, 32'd0);
    start_op(MD_MULTU, 32'd2, 32'd2);
    wait_done("post rst", 32'd0, 32'd0, cyc);
    check("post rst latency", cyc, 32'd33);
    check("post rst lo", lo, 32'd4);
    check("post rst hi", hi, 32'd0);

    // Back-to-back: new start sampled on the done cycle
    start_op(MD_DIVU, 32'd9, 32'd4);
    wait_done("b2b first", 32'd0, 32'd4, cyc);
    check("b2b first latency", cyc, 32'd33);
    check("b2b first hi", hi, 32'd1);
    check("b2b first lo", lo, 32'd2);
    start = 1'b1; op = MD_MULTU; x = 32'd6; y = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted", {31'd0, busy}, 32'd1);
    wait_done("b2b second", 32'd1, 32'd2, cyc);
    check("b2b second latency", cyc, 32'd33);
    check("b2b second hi", hi, 32'd0);
    check("b2b second lo", lo, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name:
muldiv_hilo

Overview:
- Sequential multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Replaces the single-cycle 64-bit multiply and divide/remainder datapath on the execute side.
- Accepts one operation on a start strobe, iterates one bit per cycle, then writes HI/LO and pulses done.
- Execute/stall logic reads hi/lo for MFHI/MFLO and holds the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width and HI/LO width; fixed at 32 for the core, bench exercises only 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe, sampled on clk rising edge
- op  in  3  operation code; package constants MD_MULTU, MD_MULT, MD_DIVU, MD_DIV, MD_MTHI, MD_MTLO
- X  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- Y  in  WIDTH  multiplier / divisor
- busy  out  1  high while an iterative operation is in flight
- done  out  1  one-cycle pulse on the cycle HI/LO take a mul/div result
- hi  out  WIDTH  HI register: product[63:32] or remainder
- lo  out  WIDTH  LO register: product[31:0] or quotient

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, hi=0, lo=0, and all internal state cleared. An operation in flight is abandoned and produces no done.
- Op codes: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO. Codes 6 and 7 are no-ops.
- start is honoured only in IDLE. start while busy=1 is ignored completely: no queueing, and no change to operands, hi or lo.
- MTHI/MTLO in IDLE: hi (or lo) <= X at that edge. State stays IDLE; busy and done stay 0.
- MUL/DIV accepted at edge E0:
  - Latch op and sign flags.
  - Latch operand magnitudes: two's-complement absolute value for MULT/DIV. abs(0x80000000) = 0x80000000 as unsigned.
  - Clear the 64-bit accumulator and the 5-bit counter. Enter RUN; busy=1 from E0.
- State RUN, edges E1..E32, one iteration each; counter increments and wraps 31->0 to exit RUN at E32.
  - Multiply: shift-add, LSB-first on the multiplier, 64-bit unsigned product.
  - Divide: restoring, MSB-first; 32-bit quotient and remainder.
- State FIX, edge E33:
  - Signed correction: product negated if sign(X) != sign(Y); quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo. done=1 for the cycle after E33. busy=0 after E33, state IDLE.
- Latency: result visible on hi/lo 33 cycles after start is sampled. A new start is accepted on the same edge that done is high.
- hi/lo hold their previous values throughout RUN and change only at E33, MTHI/MTLO, or reset.
- Divide by zero (DIV or DIVU, Y=0): lo=0xFFFFFFFF, hi=X unchanged (no sign correction). Timing is normal, 33 cycles with done.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap, no flag.
- No overflow or carry outputs; all arithmetic is modulo 2^64 / 2^32 as described.

Decomposition:
- Package muldiv_pkg holds:
  - op code constants MD_MULTU..MD_MTLO and op width 3;
  - state encoding IDLE/RUN/FIX as a 2-bit enum;
  - ITER_COUNT=32.
- One natural sub-module: muldiv_step. It is combinational and does one shift-add or one restore-subtract step on accumulator, operand and mode, returning the next accumulator. The top holds the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULTU X=0xFFFFFFFF Y=0xFFFFFFFF -> busy 33 cycles, done pulse, hi=0xFFFFFFFE lo=0x00000001.
- MULT X=0xFFFFFFFD (-3) Y=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; then DIV X=0xFFFFFFF9 (-7) Y=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; then DIVU X=100 Y=7 -> lo=14 hi=2.
- DIVU X=0x12345678 Y=0 -> lo=0xFFFFFFFF hi=0x12345678; DIV X=0x80000000 Y=0xFFFFFFFF -> lo=0x80000000 hi=0.
- MTHI X=0xA5A5A5A5, next cycle MTLO X=0x5A5A5A5A -> hi/lo updated one edge after each, busy and done stay 0. Then MULTU 3*5 with a second start (op DIVU) at cycle 10 -> second start ignored, hi=0 lo=15.
- MULTU 2*2 started, rst asserted asynchronously mid-cycle at cycle 10 -> busy, done, hi and lo go to 0 immediately with no later done. A start after rst release completes normally.
- Back-to-back: DIVU 9/4 with a new MULTU 6*7 start on the done cycle -> first result hi=1 lo=2, second done exactly 33 cycles later with hi=0 lo=42.
